// File: rtl/poly_dispatch_ctrl.sv
// rtl/poly_dispatch_ctrl.sv - round-robin dispatcher and in-order collector for replicated polynomial pipelines
// Optional saturating accept/stall counters are built when DISPATCH_PERF_CNT_EN is defined.
module poly_dispatch_ctrl #(
    parameter int WIDTH        = 8,
    parameter int NUM_PIPES    = 8,
    parameter int PIPE_LATENCY = 4,
    parameter int RST_LATENCY  = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           flush,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [WIDTH-1:0]                               in_x,
    output logic                                           pipe_en,
    output logic [NUM_PIPES*WIDTH-1:0]                     pipe_x,
    input  logic [NUM_PIPES*4*WIDTH-1:0]                   pipe_out,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [4*WIDTH-1:0]                             out_data,
    output logic [(NUM_PIPES>1?$clog2(NUM_PIPES):1)-1:0]   out_pipe_idx,
    output logic                                           busy,
    output logic [15:0]                                    accept_cnt,
    output logic [15:0]                                    stall_cnt
);
    localparam int IW        = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int OW        = 4 * WIDTH;
    localparam int CW        = (RST_LATENCY > 1) ? $clog2(RST_LATENCY) : 1;
    localparam int INIT_LAST = (RST_LATENCY > 0) ? RST_LATENCY - 1 : 0;
    localparam int LAST      = PIPE_LATENCY - 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [CW-1:0]                    init_cnt_q, init_cnt_d;
    logic [IW-1:0]                    rr_q, rr_d;
    logic [PIPE_LATENCY-1:0]          trk_vld_q, trk_vld_d;
    logic [PIPE_LATENCY-1:0][IW-1:0]  trk_idx_q, trk_idx_d;
    logic                             stall, accept, trk_empty;

    assign trk_empty    = ~|trk_vld_q;
    assign out_valid    = (state_q != ST_INIT) & trk_vld_q[LAST];
    assign stall        = out_valid & ~out_ready;
    assign pipe_en      = (state_q != ST_INIT) & ~stall;
    assign in_ready     = (state_q == ST_RUN) & ~stall & ~flush;
    assign accept       = in_valid & in_ready;
    assign busy         = (state_q != ST_RUN) | ~trk_empty;
    assign out_pipe_idx = out_valid ? trk_idx_q[LAST] : '0;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (out_valid && trk_idx_q[LAST] == IW'(i)) begin
                out_data = pipe_out[i*OW +: OW];
            end
        end
    end

    always_comb begin
        pipe_x = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (accept && rr_q == IW'(i)) begin
                pipe_x[i*WIDTH +: WIDTH] = in_x;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_d       = rr_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == CW'(INIT_LAST)) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Restart dispatch from pipe 0 once nothing is left in flight
                if (trk_empty) begin
                    state_d = ST_RUN;
                    rr_d    = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (accept) begin
            rr_d = (rr_q == IW'(NUM_PIPES - 1)) ? '0 : rr_q + IW'(1);
        end
    end

    always_comb begin
        trk_vld_d = trk_vld_q;
        trk_idx_d = trk_idx_q;
        if (pipe_en) begin
            trk_vld_d[0] = accept;
            trk_idx_d[0] = rr_q;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                trk_vld_d[k] = trk_vld_q[k-1];
                trk_idx_d[k] = trk_idx_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rr_q       <= '0;
            trk_vld_q  <= '0;
            trk_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_q       <= rr_d;
            trk_vld_q  <= trk_vld_d;
            trk_idx_q  <= trk_idx_d;
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    logic [15:0] accept_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (accept && accept_cnt_q != 16'hFFFF) begin
                accept_cnt_q <= accept_cnt_q + 16'd1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign accept_cnt = accept_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`else
    assign accept_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_poly_dispatch_ctrl.sv
// tb/tb_poly_dispatch_ctrl.sv - scoreboard bench for poly_dispatch_ctrl with behavioural pipelines f(x)=20x^2+40x+40
module tb_poly_dispatch_ctrl;
    localparam int WIDTH = 8;
    localparam int NP    = 8;
    localparam int PL    = 4;
    localparam int RL    = 4;
    localparam int OW    = 4 * WIDTH;
    localparam int IW    = 3;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, pipe_en, out_valid, out_ready, busy;
    logic [WIDTH-1:0]  in_x;
    logic [NP*WIDTH-1:0] pipe_x;
    logic [NP*OW-1:0]  pipe_out;
    logic [OW-1:0]     out_data;
    logic [IW-1:0]     out_pipe_idx;
    logic [15:0]       accept_cnt, stall_cnt;

    always #5 clk = ~clk;

    poly_dispatch_ctrl #(.WIDTH(WIDTH), .NUM_PIPES(NP), .PIPE_LATENCY(PL), .RST_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .pipe_en(pipe_en), .pipe_x(pipe_x), .pipe_out(pipe_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_pipe_idx(out_pipe_idx), .busy(busy),
        .accept_cnt(accept_cnt), .stall_cnt(stall_cnt)
    );

    // Behavioural pipelines, each PL enabled stages deep
    logic [OW-1:0] pl [NP][PL];

    function automatic logic [OW-1:0] poly(input logic [WIDTH-1:0] x);
        logic [OW-1:0] v;
        v = OW'(x);
        return 32'd20 * v * v + 32'd40 * v + 32'd40;
    endfunction

    always @(posedge clk) begin
        if (pipe_en) begin
            for (int i = 0; i < NP; i++) begin
                pl[i][0] <= poly(pipe_x[i*WIDTH +: WIDTH]);
                for (int k = 1; k < PL; k++) pl[i][k] <= pl[i][k-1];
            end
        end
    end

    always_comb begin
        pipe_out = '0;
        for (int i = 0; i < NP; i++) pipe_out[i*OW +: OW] = pl[i][PL-1];
    end

    logic [OW-1:0] exp_tab [0:10] = '{32'd40, 32'd100, 32'd200, 32'd340, 32'd520, 32'd740,
                                      32'd1000, 32'd1300, 32'd1640, 32'd2020, 32'd2440};

    typedef struct {
        logic [OW-1:0] data;
        logic [IW-1:0] idx;
        int            edge_no;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            errors = 0;
    int            checks = 0;
    int            en_done = 0;
    logic          pe_last = 1'b0;
    logic [IW-1:0] rr_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts enabled edges, pops/compares results, pushes expectations on accept
    always @(negedge clk) begin
        en_done += int'(pe_last);
        if (rst) begin
            q.delete();
            rr_m = '0;
        end else begin
            if (out_valid && q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_output: got data %0d with no result expected", out_data);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_pipe_idx", 64'(out_pipe_idx), 64'(e.idx));
                chk("latency_edges", 64'(en_done), 64'(e.edge_no + PL - 1));
            end
            if (in_valid && in_ready) begin
                chk("pipe_x_route", 64'(pipe_x), 64'(in_x) << (int'(rr_m) * WIDTH));
                q.push_back('{exp_tab[in_x], rr_m, en_done + 1});
                rr_m = (rr_m == IW'(NP - 1)) ? '0 : rr_m + IW'(1);
            end
            if (flush) rr_m = '0;
        end
        pe_last = pipe_en;
    end

    task automatic send(input logic [WIDTH-1:0] x, output int waits);
        bit ok;
        ok = 0;
        waits = 0;
        in_valid = 1'b1;
        in_x = x;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) waits++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept for x=%0d expected accept", x);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queue_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, nres, rdy;
        int exp_acc, exp_stall;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_x = 8'd1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_pipe_en", 64'(pipe_en), 64'd0);
        chk("rst_pipe_x", 64'(pipe_x), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_pipe_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_accept_cnt", 64'(accept_cnt), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < RL; c++) begin
            @(negedge clk);
            chk("init_in_ready", 64'(in_ready), 64'd0);
            chk("init_pipe_en", 64'(pipe_en), 64'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back x=1..10, first accept right after INIT
        send(8'd1, w);
        chk("first_accept_wait", 64'(w), 64'd0);
        for (int x = 2; x <= 10; x++) send(WIDTH'(x), w);
        wait_drain();
        chk("idle_busy", 64'(busy), 64'd0);
`ifdef DISPATCH_PERF_CNT_EN
        exp_acc = 10;
`else
        exp_acc = 0;
`endif
        chk("accept_cnt_10", 64'(accept_cnt), 64'(exp_acc));

        // Backpressure: hold out_ready low for three stalled cycles
        out_ready = 1'b0;
        for (int x = 1; x <= 4; x++) send(WIDTH'(x), w);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_pipe_en", 64'(pipe_en), 64'd0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_data", 64'(out_data), 64'd100);
            chk("stall_out_idx", 64'(out_pipe_idx), 64'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();
`ifdef DISPATCH_PERF_CNT_EN
        exp_acc = 14;
        exp_stall = 3;
`else
        exp_acc = 0;
        exp_stall = 0;
`endif
        chk("stall_cnt_3", 64'(stall_cnt), 64'(exp_stall));
        chk("accept_cnt_14", 64'(accept_cnt), 64'(exp_acc));

        // Flush with three results in flight; x=9 offered throughout
        for (int x = 6; x <= 8; x++) send(WIDTH'(x), w);
        flush = 1'b1;
        in_valid = 1'b1;
        in_x = 8'd9;
        @(negedge clk);
        chk("flush_same_cycle_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        nres = 0;
        rdy = 0;
        for (int c = 0; c < 30 && rdy == 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                nres++;
                chk("drain_in_ready", 64'(in_ready), 64'd0);
            end
            rdy = int'(in_ready);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("drain_resumed", 64'(rdy), 64'd1);
        chk("drain_results", 64'(nres), 64'd3);
        wait_drain();

        // Reset with four results in flight
        for (int x = 1; x <= 4; x++) send(WIDTH'(x), w);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_accept_cnt", 64'(accept_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < RL + 12; c++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        send(8'd5, w);
        wait_drain();
        chk("final_busy", 64'(busy), 64'd0);
`ifdef DISPATCH_PERF_CNT_EN
        exp_acc = 1;
`else
        exp_acc = 0;
`endif
        chk("accept_cnt_after_rst", 64'(accept_cnt), 64'(exp_acc));
        chk("final_stall_cnt", 64'(stall_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
